// File: rtl/alarm_ctrl.sv
// Alarm clock controller: time of day, set modes, and ring/snooze sequencing.
// All state advances on Clock_5K; seconds advance on the rising edge of Clock_1Sec.
module alarm_ctrl #(
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic       Clock_1Sec,
    input  logic       Btn_Mode,
    input  logic       Btn_Hour,
    input  logic       Btn_Min,
    input  logic       Btn_Alarm,
    input  logic       Btn_Snooze,
    output logic [4:0] Hour,
    output logic [5:0] Minute,
    output logic [5:0] Second,
    output logic [4:0] Alarm_Hour,
    output logic [5:0] Alarm_Min,
    output logic       Alarm_En,
    output logic [1:0] Mode,
    output logic [1:0] Alarm_State,
    output logic       Buzzer
);

    localparam int unsigned HW  = 5;
    localparam int unsigned MW  = 6;
    localparam int unsigned SNW = 12;
    localparam int unsigned RNW = 8;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'b00,
        MODE_SET_TIME  = 2'b01,
        MODE_SET_ALARM = 2'b10,
        MODE_BAD       = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        AL_IDLE    = 2'b00,
        AL_RINGING = 2'b01,
        AL_SNOOZED = 2'b10,
        AL_BAD     = 2'b11
    } alarm_e;

    logic           c1s_q;
    mode_e          mode_q, mode_d;
    alarm_e         al_state_q, al_state_d;
    logic [HW-1:0]  hour_q, hour_d, al_hour_q, al_hour_d;
    logic [MW-1:0]  min_q, min_d, sec_q, sec_d, al_min_q, al_min_d;
    logic           al_en_q, al_en_d;
    logic [RNW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNW-1:0] snz_cnt_q, snz_cnt_d;

    logic sec_tick, enter_set, run_time, time_hit;

    function automatic logic [HW-1:0] inc_hour(input logic [HW-1:0] h);
        return (h == HW'(23)) ? HW'(0) : HW'(h + HW'(1));
    endfunction

    function automatic logic [MW-1:0] inc_min(input logic [MW-1:0] m);
        return (m == MW'(59)) ? MW'(0) : MW'(m + MW'(1));
    endfunction

    // State register
    always_ff @(posedge Clock_5K or negedge Reset) begin
        if (!Reset) begin
            c1s_q      <= 1'b0;
            mode_q     <= MODE_RUN;
            al_state_q <= AL_IDLE;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            al_hour_q  <= '0;
            al_min_q   <= '0;
            al_en_q    <= 1'b0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
        end else begin
            c1s_q      <= Clock_1Sec;
            mode_q     <= mode_d;
            al_state_q <= al_state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            al_en_q    <= al_en_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end

    // Time-of-day and alarm-setting datapath; a tick that lands on SET_TIME entry is dropped
    always_comb begin
        sec_tick  = Clock_1Sec & ~c1s_q;
        enter_set = Btn_Mode && (mode_q == MODE_RUN);
        run_time  = sec_tick && !enter_set &&
                    ((mode_q == MODE_RUN) || (mode_q == MODE_SET_ALARM));
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        al_en_d   = al_en_q ^ Btn_Alarm;

        if (enter_set) begin
            sec_d = '0;
        end else if (run_time) begin
            sec_d = inc_min(sec_q);
            if (sec_q == MW'(59)) begin
                min_d = inc_min(min_q);
                if (min_q == MW'(59)) begin
                    hour_d = inc_hour(hour_q);
                end
            end
        end else if ((mode_q == MODE_SET_TIME) && !Btn_Mode) begin
            if (Btn_Hour) hour_d = inc_hour(hour_q);
            if (Btn_Min)  min_d  = inc_min(min_q);
        end

        if ((mode_q == MODE_SET_ALARM) && !Btn_Mode) begin
            if (Btn_Hour) al_hour_d = inc_hour(al_hour_q);
            if (Btn_Min)  al_min_d  = inc_min(al_min_q);
        end

        time_hit = run_time && (hour_d == al_hour_q) && (min_d == al_min_q) &&
                   (sec_d == MW'(0));
    end

    // Next-state logic for mode and alarm sequencing
    always_comb begin
        mode_d     = mode_q;
        al_state_d = al_state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;

        if (Btn_Mode) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_TIME;
                MODE_SET_TIME: mode_d = MODE_SET_ALARM;
                default:       mode_d = MODE_RUN;
            endcase
        end else if (mode_q == MODE_BAD) begin
            mode_d = MODE_RUN;
        end

        case (al_state_q)
            AL_IDLE: begin
                if (time_hit && al_en_d) begin
                    al_state_d = AL_RINGING;
                    ring_cnt_d = '0;
                end
            end
            AL_RINGING: begin
                if (Btn_Alarm) begin
                    al_state_d = AL_IDLE;
                    ring_cnt_d = '0;
                end else if (Btn_Snooze) begin
                    al_state_d = AL_SNOOZED;
                    ring_cnt_d = '0;
                    snz_cnt_d  = SNW'(SNOOZE_SEC);
                end else if (sec_tick) begin
                    if (ring_cnt_q >= RNW'(RING_SEC - 1)) begin
                        al_state_d = AL_IDLE;
                        ring_cnt_d = '0;
                    end else begin
                        ring_cnt_d = RNW'(ring_cnt_q + RNW'(1));
                    end
                end
            end
            AL_SNOOZED: begin
                if (Btn_Alarm) begin
                    al_state_d = AL_IDLE;
                    snz_cnt_d  = '0;
                end else if (sec_tick) begin
                    if (snz_cnt_q <= SNW'(1)) begin
                        al_state_d = AL_RINGING;
                        ring_cnt_d = '0;
                        snz_cnt_d  = '0;
                    end else begin
                        snz_cnt_d = SNW'(snz_cnt_q - SNW'(1));
                    end
                end
            end
            default: begin
                al_state_d = AL_IDLE;
                ring_cnt_d = '0;
                snz_cnt_d  = '0;
            end
        endcase
    end

    // Outputs; the buzzer beeps with the 1 Hz square wave while ringing
    always_comb begin
        Hour        = hour_q;
        Minute      = min_q;
        Second      = sec_q;
        Alarm_Hour  = al_hour_q;
        Alarm_Min   = al_min_q;
        Alarm_En    = al_en_q;
        Mode        = mode_q;
        Alarm_State = al_state_q;
        Buzzer      = (al_state_q == AL_RINGING) & Clock_1Sec;
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (SNOOZE_SEC=3, RING_SEC=60).
module tb_alarm_ctrl;

    logic       Clock_5K   = 1'b0;
    logic       Reset      = 1'b0;
    logic       Clock_1Sec = 1'b0;
    logic       Btn_Mode   = 1'b0;
    logic       Btn_Hour   = 1'b0;
    logic       Btn_Min    = 1'b0;
    logic       Btn_Alarm  = 1'b0;
    logic       Btn_Snooze = 1'b0;
    logic [4:0] Hour;
    logic [5:0] Minute;
    logic [5:0] Second;
    logic [4:0] Alarm_Hour;
    logic [5:0] Alarm_Min;
    logic       Alarm_En;
    logic [1:0] Mode;
    logic [1:0] Alarm_State;
    logic       Buzzer;

    int checks   = 0;
    int failures = 0;

    alarm_ctrl #(.SNOOZE_SEC(3), .RING_SEC(60)) dut (
        .Clock_5K    (Clock_5K),
        .Reset       (Reset),
        .Clock_1Sec  (Clock_1Sec),
        .Btn_Mode    (Btn_Mode),
        .Btn_Hour    (Btn_Hour),
        .Btn_Min     (Btn_Min),
        .Btn_Alarm   (Btn_Alarm),
        .Btn_Snooze  (Btn_Snooze),
        .Hour        (Hour),
        .Minute      (Minute),
        .Second      (Second),
        .Alarm_Hour  (Alarm_Hour),
        .Alarm_Min   (Alarm_Min),
        .Alarm_En    (Alarm_En),
        .Mode        (Mode),
        .Alarm_State (Alarm_State),
        .Buzzer      (Buzzer)
    );

    always #5 Clock_5K = ~Clock_5K;

    task automatic step();
        @(posedge Clock_5K);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic m, input logic h, input logic mn, input logic a, input logic s);
        Btn_Mode = m; Btn_Hour = h; Btn_Min = mn; Btn_Alarm = a; Btn_Snooze = s;
        step();
        Btn_Mode = 0; Btn_Hour = 0; Btn_Min = 0; Btn_Alarm = 0; Btn_Snooze = 0;
    endtask

    task automatic press_n(input logic h, input logic mn, input int n);
        for (int i = 0; i < n; i++) press(1'b0, h, mn, 1'b0, 1'b0);
    endtask

    // One full 1 Hz period: two cycles high, two cycles low
    task automatic tick();
        Clock_1Sec = 1'b1; step(); step();
        Clock_1Sec = 1'b0; step(); step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_hour"}, 32'(Hour), 32'(h));
        chk({tag, "_min"},  32'(Minute), 32'(m));
        chk({tag, "_sec"},  32'(Second), 32'(s));
    endtask

    initial begin
        // Reset values
        step(); step(); step();
        chk_time("rst", 0, 0, 0);
        chk("rst_mode", 32'(Mode), 0);
        chk("rst_state", 32'(Alarm_State), 0);
        chk("rst_en", 32'(Alarm_En), 0);
        chk("rst_buzz", 32'(Buzzer), 0);
        Reset = 1'b1;
        step();
        tick();
        chk("first_tick_sec", 32'(Second), 1);

        // Set 23:59, freeze check, then roll over midnight
        press(1, 0, 0, 0, 0);
        chk("set_entry_mode", 32'(Mode), 1);
        chk("set_entry_sec", 32'(Second), 0);
        press_n(1, 0, 23);
        press_n(0, 1, 59);
        chk_time("set_2359", 23, 59, 0);
        tick();
        chk("frozen_sec", 32'(Second), 0);
        press(1, 0, 0, 0, 0);
        chk("mode_alarm", 32'(Mode), 2);
        press(1, 0, 0, 0, 0);
        chk("mode_run", 32'(Mode), 0);
        ticks(59);
        chk_time("pre_mid", 23, 59, 59);
        tick();
        chk_time("midnight", 0, 0, 0);
        chk("no_ring_disabled", 32'(Alarm_State), 0);
        tick();
        chk("one_adv_sec", 32'(Second), 1);

        // Alarm 06:30, time 06:29:00
        press(1, 0, 0, 0, 0);
        press_n(1, 0, 6);
        press_n(0, 1, 29);
        press(1, 0, 0, 0, 0);
        press_n(1, 0, 6);
        press_n(0, 1, 30);
        chk("al_hour", 32'(Alarm_Hour), 6);
        chk("al_min", 32'(Alarm_Min), 30);
        chk("time_untouched_hour", 32'(Hour), 6);
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        chk("en_on", 32'(Alarm_En), 1);
        ticks(59);
        chk_time("pre_alarm", 6, 29, 59);
        chk("pre_alarm_idle", 32'(Alarm_State), 0);
        Clock_1Sec = 1'b1; step();
        chk("ring_state", 32'(Alarm_State), 1);
        chk("ring_buzz_hi", 32'(Buzzer), 1);
        chk_time("ring_time", 6, 30, 0);
        step(); Clock_1Sec = 1'b0; step();
        chk("ring_buzz_lo", 32'(Buzzer), 0);
        step();
        ticks(59);
        chk("ring_59", 32'(Alarm_State), 1);
        tick();
        chk("ring_timeout", 32'(Alarm_State), 0);
        chk("timeout_en", 32'(Alarm_En), 1);

        // Snooze cycle, alarm 06:32 while in SET_ALARM
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press_n(0, 1, 2);
        ticks(59);
        chk("pre_ring2", 32'(Alarm_State), 0);
        tick();
        chk("ring2", 32'(Alarm_State), 1);
        press(0, 0, 0, 0, 1);
        chk("snoozed", 32'(Alarm_State), 2);
        Clock_1Sec = 1'b1; step();
        chk("snz_buzz", 32'(Buzzer), 0);
        step(); Clock_1Sec = 1'b0; step(); step();
        tick();
        chk("snz_2", 32'(Alarm_State), 2);
        tick();
        chk("snz_rering", 32'(Alarm_State), 1);
        press(0, 0, 0, 1, 0);
        chk("off_state", 32'(Alarm_State), 0);
        chk("off_en", 32'(Alarm_En), 0);

        // Alarm and snooze together in RINGING
        press_n(0, 1, 1);
        press(0, 0, 0, 1, 0);
        ticks(57);
        chk_time("ring3_time", 6, 33, 0);
        chk("ring3", 32'(Alarm_State), 1);
        press(0, 0, 0, 1, 1);
        chk("both_state", 32'(Alarm_State), 0);
        chk("both_en", 32'(Alarm_En), 0);
        press(0, 0, 0, 0, 1);
        chk("snz_idle_ignored", 32'(Alarm_State), 0);

        // SET_TIME edits with minute wrap, then run to 10:15:42
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press_n(1, 0, 4);
        press_n(0, 1, 26);
        chk("min59", 32'(Minute), 59);
        press_n(0, 1, 1);
        chk("min_wrap", 32'(Minute), 0);
        chk("min_wrap_hour", 32'(Hour), 10);
        press_n(0, 1, 15);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        ticks(42);
        chk_time("t101542", 10, 15, 42);
        Clock_1Sec = 1'b1; Btn_Mode = 1'b1; step();
        Btn_Mode = 1'b0;
        chk("tick_entry_mode", 32'(Mode), 1);
        chk_time("tick_entry", 10, 15, 0);
        step(); Clock_1Sec = 1'b0; step(); step();
        tick();
        chk("frozen2_sec", 32'(Second), 0);
        press(1, 1, 0, 0, 0);
        chk("mode_prio_mode", 32'(Mode), 2);
        chk("mode_prio_hour", 32'(Hour), 10);
        chk("mode_prio_alhour", 32'(Alarm_Hour), 6);

        // Reset while snoozed
        press_n(1, 0, 4);
        press_n(0, 1, 43);
        press(0, 0, 0, 1, 0);
        ticks(60);
        chk_time("ring4_time", 10, 16, 0);
        chk("ring4", 32'(Alarm_State), 1);
        press(0, 0, 0, 0, 1);
        tick();
        Clock_1Sec = 1'b1; step();
        chk("pre_rst_snz", 32'(Alarm_State), 2);
        Reset = 1'b0;
        #2;
        chk_time("mid_rst", 0, 0, 0);
        chk("mid_rst_state", 32'(Alarm_State), 0);
        chk("mid_rst_mode", 32'(Mode), 0);
        chk("mid_rst_en", 32'(Alarm_En), 0);
        chk("mid_rst_alhour", 32'(Alarm_Hour), 0);
        chk("mid_rst_almin", 32'(Alarm_Min), 0);
        chk("mid_rst_buzz", 32'(Buzzer), 0);
        Clock_1Sec = 1'b0;
        step();
        Reset = 1'b1;
        step();
        tick();
        chk("post_rst_sec", 32'(Second), 1);
        chk("post_rst_state", 32'(Alarm_State), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
